puf_response_collector: RTL and testbench
=========================================

PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

Interface
REQ-001 SHALL provide parameter WINDOW, default 255, meaning oscillator count-window length in clk cycles (legal 1..255).
REQ-002 SHALL provide parameter SETTLE, default 2, meaning idle cycles after the window before counts are sampled (legal 1..3).
REQ-003 SHALL provide port clk, input, 1, meaning the single clock for all state.
REQ-004 SHALL provide port rst_n, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL provide port start, input, 1, meaning request for one 8-bit response; sampled only in IDLE.
REQ-006 SHALL provide port chal_base, input, 5, meaning first challenge index, latched when start is accepted.
REQ-007 SHALL provide port cnt_a, input, 8, meaning count from oscillator bank A.
REQ-008 SHALL provide port cnt_b, input, 8, meaning count from oscillator bank B.
REQ-009 SHALL provide port cnt_clr, output, 1, meaning counter clear to both banks.
REQ-010 SHALL provide port cnt_en, output, 1, meaning oscillator enable (drives ena of both banks).
REQ-011 SHALL provide port chal, output, 5, meaning current challenge / mux select.
REQ-012 SHALL provide port busy, output, 1, meaning high in every state except IDLE.
REQ-013 SHALL provide port resp, output, 8, meaning collected response word.
REQ-014 SHALL provide port resp_valid, output, 1, meaning resp is complete and stable.
REQ-015 SHALL provide port resp_ready, input, 1, meaning consumer accepts resp.

Function
REQ-016 SHALL implement states IDLE, CLEAR, COUNT, WAIT, COMPARE, DONE; all outputs registered.
REQ-017 IDLE: start=1 at an edge SHALL latch chal<=chal_base, bit index<=0, resp<=0, next state CLEAR.
REQ-018 CLEAR: cnt_clr=1 for exactly one cycle, cnt_en=0; timer<=WINDOW-1; next COUNT.
REQ-019 COUNT: cnt_en=1 for exactly WINDOW cycles; timer decrements; at timer==0 next WAIT.
REQ-020 WAIT: cnt_en=0 for exactly SETTLE cycles; next COMPARE.
REQ-021 COMPARE: bit = (cnt_a > cnt_b), unsigned 8-bit; tie (cnt_a==cnt_b) SHALL give 0; resp[index]<=bit (bit 0 first).
REQ-022 COMPARE: if index==7 next DONE, else index+1, chal<=chal+1 modulo 32 (31 wraps to 0), next CLEAR.
REQ-023 Per-bit cost SHALL be WINDOW+SETTLE+2 cycles; with start accepted at edge k, resp_valid rises at edge k+8*(WINDOW+SETTLE+2).
REQ-024 DONE: resp_valid=1 and resp held until an edge with resp_ready=1; then resp_valid=0, next IDLE; resp retains value.
REQ-025 resp_ready=1 while resp_valid=0 SHALL have no effect; start while busy=1 SHALL be ignored (not queued).
REQ-026 start and resp_ready both high in DONE SHALL only complete the handshake; new start is honoured from IDLE next cycle onward.

Reset
REQ-027 rst_n=1 SHALL asynchronously force IDLE, chal=0, index=0, timer=0, resp=0, resp_valid=0, busy=0, cnt_en=0, cnt_clr=0.
REQ-028 Reset mid-COUNT SHALL drop cnt_en in the same cycle as assertion and discard partial resp; operation resumes only on a new start after release.

Configuration
REQ-029 With PUF_TIE_FLAG_EN defined, SHALL add output tie_mask[7:0]: bit i=1 when response bit i was a tie; cleared on start accept and reset, valid with resp_valid.
REQ-030 Without PUF_TIE_FLAG_EN, tie_mask port SHALL not exist; ties silently yield 0.

Verification (WINDOW=16, SETTLE=2 unless stated)
REQ-031 Reset, start=1 one cycle, chal_base=5 -> chal steps 5..12, cnt_clr pulses 8 times, resp_valid at 8*20=160 cycles after accept.
REQ-032 cnt_a=200, cnt_b=100 constant -> resp=0xFF; cnt_a=10, cnt_b=10 -> resp=0x00 and (with macro) tie_mask=0xFF.
REQ-033 chal_base=30 -> chal sequence 30,31,0,1,2,3,4,5; cnt_en high exactly 16 cycles per bit.
REQ-034 resp_ready held low 50 cycles after resp_valid -> resp/resp_valid stable; resp_ready=1 -> resp_valid low next cycle, busy=0.
REQ-035 Assert rst_n during 4th COUNT window -> cnt_en=0 immediately, resp=0; repeat start -> full 8-bit sequence restarts from chal_base.
REQ-036 start pulsed while busy -> no effect; exactly one resp_valid per accepted start.

Source files
------------

// File: rtl/puf_response_collector_if.sv
// Host-side handshake bundle for the PUF response collector:
// start/challenge request, busy status and the valid/ready response transfer.
interface puf_response_collector_if;
    logic       start;
    logic [4:0] chal_base;
    logic       busy;
    logic [7:0] resp;
    logic       resp_valid;
    logic       resp_ready;

    modport master (
        output start, chal_base, resp_ready,
        input  busy, resp, resp_valid
    );

    modport slave (
        input  start, chal_base, resp_ready,
        output busy, resp, resp_valid
    );
endinterface

// File: rtl/puf_response_collector.sv
// Ring-oscillator PUF collector: races banks A and B once per challenge and packs eight compare bits.
// Optional PUF_TIE_FLAG_EN adds tie_mask output flagging bits that came from equal counts.
module puf_response_collector #(
    parameter int unsigned WINDOW = 255,
    parameter int unsigned SETTLE = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,  // active-high despite the name
    puf_response_collector_if.slave   host,
    input  logic [7:0]                cnt_a,
    input  logic [7:0]                cnt_b,
    output logic                      cnt_clr,
    output logic                      cnt_en,
    output logic [4:0]                chal
`ifdef PUF_TIE_FLAG_EN
    ,
    output logic [7:0]                tie_mask
`endif
);

    localparam logic [7:0] WIN_LOAD    = 8'(WINDOW - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COUNT,
        WAIT,
        COMPARE,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] chal_q, chal_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] resp_q, resp_d;
    logic       resp_valid_q, resp_valid_d;
    logic       busy_q, busy_d;
    logic       cnt_en_q, cnt_en_d;
    logic       cnt_clr_q, cnt_clr_d;
    logic [7:0] tie_q, tie_d;

    always_comb begin
        state_d      = state_q;
        chal_d       = chal_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        resp_d       = resp_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
        cnt_en_d     = cnt_en_q;
        cnt_clr_d    = cnt_clr_q;
        tie_d        = tie_q;

        case (state_q)
            IDLE: begin
                if (host.start) begin
                    chal_d    = host.chal_base;
                    idx_d     = 3'd0;
                    resp_d    = 8'd0;
                    tie_d     = 8'd0;
                    busy_d    = 1'b1;
                    cnt_clr_d = 1'b1;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                cnt_clr_d = 1'b0;
                cnt_en_d  = 1'b1;
                timer_d   = WIN_LOAD;
                state_d   = COUNT;
            end
            COUNT: begin
                if (timer_q == 8'd0) begin
                    cnt_en_d = 1'b0;
                    timer_d  = SETTLE_LOAD;
                    state_d  = WAIT;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            WAIT: begin
                if (timer_q == 8'd0) begin
                    state_d = COMPARE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            COMPARE: begin
                // Strict greater-than: a tie resolves to 0.
                resp_d[idx_q] = (cnt_a > cnt_b);
                tie_d[idx_q]  = (cnt_a == cnt_b);
                if (idx_q == 3'd7) begin
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    idx_d     = idx_q + 3'd1;
                    chal_d    = chal_q + 5'd1;
                    cnt_clr_d = 1'b1;
                    state_d   = CLEAR;
                end
            end
            DONE: begin
                if (host.resp_ready) begin
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= IDLE;
            chal_q       <= 5'd0;
            idx_q        <= 3'd0;
            timer_q      <= 8'd0;
            resp_q       <= 8'd0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            cnt_en_q     <= 1'b0;
            cnt_clr_q    <= 1'b0;
            tie_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            chal_q       <= chal_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            cnt_en_q     <= cnt_en_d;
            cnt_clr_q    <= cnt_clr_d;
            tie_q        <= tie_d;
        end
    end

    assign host.busy       = busy_q;
    assign host.resp       = resp_q;
    assign host.resp_valid = resp_valid_q;
    assign cnt_en          = cnt_en_q;
    assign cnt_clr         = cnt_clr_q;
    assign chal            = chal_q;

`ifdef PUF_TIE_FLAG_EN
    assign tie_mask = tie_q;
`else
    logic unused_tie;
    assign unused_tie = ^tie_q;
`endif

endmodule

// File: tb/tb_puf_response_collector.sv
// Directed bench for puf_response_collector with WINDOW=16, SETTLE=2 (20 cycles per bit).
module tb_puf_response_collector;

    localparam int W       = 16;
    localparam int S       = 2;
    localparam int RESP_CY = 8 * (W + S + 2);

    logic       clk;
    logic       rst_n;
    logic [7:0] cnt_a, cnt_b;
    logic [7:0] cnt_a_drv, cnt_b_drv;
    logic       pat_mode;
    logic       cnt_clr, cnt_en;
    logic [4:0] chal;
`ifdef PUF_TIE_FLAG_EN
    logic [7:0] tie_mask;
`endif

    int checks;
    int errors;

    puf_response_collector_if if_h();

    puf_response_collector #(.WINDOW(W), .SETTLE(S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .host    (if_h),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .chal    (chal)
`ifdef PUF_TIE_FLAG_EN
        ,
        .tie_mask(tie_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern mode: odd challenges win (50 > 45), even ones lose (40 < 45).
    assign cnt_a = pat_mode ? (chal[0] ? 8'd50 : 8'd40) : cnt_a_drv;
    assign cnt_b = pat_mode ? 8'd45 : cnt_b_drv;

    int         clr_total;
    int         en_run;
    int         run_total;
    int         valid_rise;
    logic       valid_prev;
    logic [4:0] chal_log [64];
    int         run_log [64];

    initial begin
        clr_total  = 0;
        en_run     = 0;
        run_total  = 0;
        valid_rise = 0;
        valid_prev = 1'b0;
    end

    always @(negedge clk) begin
        if (cnt_clr === 1'b1) begin
            chal_log[clr_total % 64] = chal;
            clr_total++;
        end
        if (cnt_en === 1'b1) begin
            en_run++;
        end else if (en_run != 0) begin
            run_log[run_total % 64] = en_run;
            run_total++;
            en_run = 0;
        end
        if (if_h.resp_valid === 1'b1 && valid_prev !== 1'b1) valid_rise++;
        valid_prev = if_h.resp_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int pulse_at, output int n);
        n = 0;
        while (if_h.resp_valid !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (n == pulse_at) begin
                if_h.start     = 1'b1;
                if_h.chal_base = 5'd17;
            end else if (n == pulse_at + 1) begin
                if_h.start = 1'b0;
            end
        end
    endtask

    task automatic chk_seq(input int clr_base, input int run_base, input int base);
        chk("clr_pulses", 32'(clr_total - clr_base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("chal_seq", 32'(chal_log[(clr_base + i) % 64]), 32'((base + i) % 32));
            chk("en_len", 32'(run_log[(run_base + i) % 64]), 32'(W));
        end
    endtask

    initial begin
        int n;
        int bad;
        int clr_base;
        int run_base;

        checks          = 0;
        errors          = 0;
        rst_n           = 1'b1;
        pat_mode        = 1'b0;
        cnt_a_drv       = 8'd0;
        cnt_b_drv       = 8'd0;
        if_h.start      = 1'b0;
        if_h.chal_base  = 5'd0;
        if_h.resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(if_h.busy), 32'd0);
        chk("rst_valid", 32'(if_h.resp_valid), 32'd0);
        chk("rst_resp", 32'(if_h.resp), 32'd0);
        chk("rst_chal", 32'(chal), 32'd0);
        chk("rst_en", 32'(cnt_en), 32'd0);
        chk("rst_clr", 32'(cnt_clr), 32'd0);
        rst_n = 1'b0;

        // Run 1: A always faster, chal_base 5
        repeat (2) @(negedge clk);
        cnt_a_drv      = 8'd200;
        cnt_b_drv      = 8'd100;
        clr_base       = clr_total;
        run_base       = run_total;
        if_h.chal_base = 5'd5;
        if_h.start     = 1'b1;
        @(posedge clk);
        #1;
        if_h.start = 1'b0;
        chk("accept_busy", 32'(if_h.busy), 32'd1);
        chk("accept_chal", 32'(chal), 32'd5);
        wait_valid(-10, n);
        chk("lat_run1", 32'(n), 32'(RESP_CY));
        chk("resp_run1", 32'(if_h.resp), 32'hFF);
        chk_seq(clr_base, run_base, 5);

        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (if_h.resp_valid !== 1'b1 || if_h.resp !== 8'hFF || if_h.busy !== 1'b1) bad++;
        end
        chk("hold_stable", 32'(bad), 32'd0);
        if_h.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        if_h.resp_ready = 1'b0;
        chk("hs1_valid", 32'(if_h.resp_valid), 32'd0);
        chk("hs1_busy", 32'(if_h.busy), 32'd0);
        chk("hs1_resp_kept", 32'(if_h.resp), 32'hFF);

        // Run 2: equal counts, chal wraps 30,31,0..5, stray start while busy
        repeat (3) @(negedge clk);
        cnt_a_drv      = 8'd10;
        cnt_b_drv      = 8'd10;
        clr_base       = clr_total;
        run_base       = run_total;
        if_h.chal_base = 5'd30;
        if_h.start     = 1'b1;
        @(posedge clk);
        #1;
        if_h.start = 1'b0;
        wait_valid(50, n);
        chk("lat_run2", 32'(n), 32'(RESP_CY));
        chk("resp_tie", 32'(if_h.resp), 32'h00);
`ifdef PUF_TIE_FLAG_EN
        chk("tie_mask", 32'(tie_mask), 32'hFF);
`endif
        chk_seq(clr_base, run_base, 30);

        // Handshake with start also high: only completes the handshake
        clr_base        = clr_total;
        run_base        = run_total;
        if_h.resp_ready = 1'b1;
        if_h.start      = 1'b1;
        if_h.chal_base  = 5'd2;
        pat_mode        = 1'b1;
        @(posedge clk);
        #1;
        chk("hs2_valid", 32'(if_h.resp_valid), 32'd0);
        chk("hs2_busy", 32'(if_h.busy), 32'd0);
        @(posedge clk);
        #1;
        if_h.start      = 1'b0;
        if_h.resp_ready = 1'b0;
        chk("run3_accept_busy", 32'(if_h.busy), 32'd1);
        chk("run3_accept_chal", 32'(chal), 32'd2);
`ifdef PUF_TIE_FLAG_EN
        chk("tie_cleared", 32'(tie_mask), 32'h00);
`endif

        // Run 3: alternating pattern -> 0xAA
        wait_valid(-10, n);
        chk("lat_run3", 32'(n), 32'(RESP_CY));
        chk("resp_pattern", 32'(if_h.resp), 32'hAA);
        chk_seq(clr_base, run_base, 2);
        if_h.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        if_h.resp_ready = 1'b0;
        chk("hs3_valid", 32'(if_h.resp_valid), 32'd0);
        pat_mode = 1'b0;

        // Run 4: reset during the fourth count window
        repeat (2) @(negedge clk);
        cnt_a_drv      = 8'd200;
        cnt_b_drv      = 8'd100;
        if_h.chal_base = 5'd7;
        if_h.start     = 1'b1;
        @(posedge clk);
        #1;
        if_h.start = 1'b0;
        repeat (66) @(posedge clk);
        #1;
        chk("mid_count_en", 32'(cnt_en), 32'd1);
        chk("mid_count_chal", 32'(chal), 32'd10);
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_en", 32'(cnt_en), 32'd0);
        chk("arst_resp", 32'(if_h.resp), 32'd0);
        chk("arst_busy", 32'(if_h.busy), 32'd0);
        chk("arst_chal", 32'(chal), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("no_resume_busy", 32'(if_h.busy), 32'd0);
        chk("no_resume_en", 32'(cnt_en), 32'd0);

        // Run 5: restart after reset; ready held high the whole time
        @(negedge clk);
        cnt_a_drv       = 8'd101;
        cnt_b_drv       = 8'd100;
        clr_base        = clr_total;
        run_base        = run_total;
        if_h.resp_ready = 1'b1;
        if_h.chal_base  = 5'd7;
        if_h.start      = 1'b1;
        @(posedge clk);
        #1;
        if_h.start = 1'b0;
        chk("run5_accept_busy", 32'(if_h.busy), 32'd1);
        wait_valid(-10, n);
        chk("lat_run5", 32'(n), 32'(RESP_CY));
        chk("resp_run5", 32'(if_h.resp), 32'hFF);
        chk_seq(clr_base, run_base, 7);
        @(posedge clk);
        #1;
        if_h.resp_ready = 1'b0;
        chk("hs5_valid", 32'(if_h.resp_valid), 32'd0);
        chk("hs5_busy", 32'(if_h.busy), 32'd0);

        repeat (3) @(negedge clk);
        chk("valid_rises", 32'(valid_rise), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
